// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB destination shadow, load-use stall, branch flush, data-memory wait freeze.
// Optional performance counters are enabled by defining HZD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef HZD_PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_ready,
  output logic [REG_AW-1:0] ex_mem_dest,
  output logic [REG_AW-1:0] mem_wb_dest,
  output logic              ex_mem_regwrite,
  output logic              mem_wb_regwrite,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              bubble_ex
`ifdef HZD_PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_rw, ex_mr, mem_rw, mem_mr, wb_rw;
  logic              loaduse, memwait;

  assign loaduse = ex_mr && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign memwait = mem_mr && !mem_ready;

  assign ex_mem_dest     = mem_rd;
  assign ex_mem_regwrite = mem_rw;
  assign mem_wb_dest     = wb_rd;
  assign mem_wb_regwrite = wb_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (memwait)              state_nxt = MEM_WAIT;
        else if (ex_branch_taken) state_nxt = RUN;
        else if (loaduse)         state_nxt = LU_STALL;
        else                      state_nxt = RUN;
      end
      LU_STALL: state_nxt = memwait ? MEM_WAIT : RUN;
      MEM_WAIT: state_nxt = memwait ? MEM_WAIT : RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // A memory freeze overrides everything; the stall state and the release cycle behave as a clean RUN.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    if (memwait) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (state == RUN) begin
      if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (loaduse) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  // x0 is never a real destination, so its write-enable is dropped on entry to EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      mem_rd <= '0;
      mem_rw <= 1'b0;
      mem_mr <= 1'b0;
      wb_rd  <= '0;
      wb_rw  <= 1'b0;
    end else if (!stall_ex) begin
      if (bubble_ex) begin
        ex_rd <= '0;
        ex_rw <= 1'b0;
        ex_mr <= 1'b0;
      end else begin
        ex_rd <= id_rd;
        ex_rw <= id_regwrite && (id_rd != '0);
        ex_mr <= id_memread;
      end
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      mem_mr <= ex_mr;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
    end
  end

`ifdef HZD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (flush_id && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; perf-counter scenario builds only with HZD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, ex_branch_taken, mem_ready;
  logic [4:0] ex_mem_dest, mem_wb_dest;
  logic       ex_mem_regwrite, mem_wb_regwrite;
  logic       stall_if, stall_id, stall_ex, flush_id, bubble_ex;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .ex_mem_dest(ex_mem_dest), .mem_wb_dest(mem_wb_dest),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .bubble_ex(bubble_ex)
`ifdef HZD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rd, input logic rw, input logic mr,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    id_rd = rd;
    id_regwrite = rw;
    id_memread = mr;
    id_rs1 = rs1;
    id_rs2 = rs2;
    #1;
  endtask

  task automatic idle(input int n);
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (2) tick();
    checks++;
    if ({ex_mem_dest, mem_wb_dest, ex_mem_regwrite, mem_wb_regwrite, stall_if, stall_id, stall_ex, flush_id, bubble_ex} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0",
               {ex_mem_dest, mem_wb_dest, ex_mem_regwrite, mem_wb_regwrite, stall_if, stall_id, stall_ex, flush_id, bubble_ex});
    end
    rst_n = 1'b1;
    // Put a load in MEM with memory not ready, then pull reset mid-freeze.
    applyStimulus(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (stall_ex !== 1'b1 || ex_mem_dest !== 5'd3) begin
      errors++;
      $display("[TB] FAIL reset_prefreeze got stall_ex=%0b dest=%0d want 1/3", stall_ex, ex_mem_dest);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_if !== 1'b0 || stall_ex !== 1'b0 || ex_mem_dest !== 5'd0 || ex_mem_regwrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async got stall_if=%0b stall_ex=%0b dest=%0d rw=%0b want 0", stall_if, stall_ex, ex_mem_dest, ex_mem_regwrite);
    end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (ex_mem_dest !== 5'd0 || mem_wb_dest !== 5'd0 || stall_if !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got ex_mem=%0d mem_wb=%0d stall_if=%0b want 0", ex_mem_dest, mem_wb_dest, stall_if);
    end
  endtask

  task automatic test_pipe_flow();
    idle(3);
    applyStimulus(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (ex_mem_dest !== 5'd0) begin
      errors++;
      $display("[TB] FAIL flow_c1 got ex_mem_dest=%0d want 0", ex_mem_dest);
    end
    tick();
    checks++;
    if (ex_mem_dest !== 5'd5 || ex_mem_regwrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flow_c2 got dest=%0d rw=%0b want 5/1", ex_mem_dest, ex_mem_regwrite);
    end
    tick();
    checks++;
    if (mem_wb_dest !== 5'd5 || mem_wb_regwrite !== 1'b1 || ex_mem_dest !== 5'd0) begin
      errors++;
      $display("[TB] FAIL flow_c3 got mem_wb=%0d rw=%0b ex_mem=%0d want 5/1/0", mem_wb_dest, mem_wb_regwrite, ex_mem_dest);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    applyStimulus(5'd7, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd8, 1'b1, 1'b0, 5'd0, 5'd7);
    checks++;
    if ({stall_if, stall_id, bubble_ex, stall_ex, flush_id} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL lu_stall got %b want 11100", {stall_if, stall_id, bubble_ex, stall_ex, flush_id});
    end
    tick();
    checks++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000 || ex_mem_dest !== 5'd7) begin
      errors++;
      $display("[TB] FAIL lu_release got ctl=%b dest=%0d want 000/7", {stall_if, stall_id, bubble_ex}, ex_mem_dest);
    end
    tick();
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (ex_mem_dest !== 5'd0 || ex_mem_regwrite !== 1'b0 || mem_wb_dest !== 5'd7) begin
      errors++;
      $display("[TB] FAIL lu_bubble got ex_mem=%0d rw=%0b mem_wb=%0d want 0/0/7", ex_mem_dest, ex_mem_regwrite, mem_wb_dest);
    end
    tick();
    checks++;
    if (ex_mem_dest !== 5'd8) begin
      errors++;
      $display("[TB] FAIL lu_consumer got ex_mem_dest=%0d want 8", ex_mem_dest);
    end
    // Same pattern on x0 must not stall, and x0 never reports a write.
    idle(3);
    applyStimulus(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
    checks++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lu_x0 got stall_if=%0b bubble_ex=%0b want 0/0", stall_if, bubble_ex);
    end
    tick();
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (ex_mem_regwrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x0_regwrite got %0b want 0", ex_mem_regwrite);
    end
  endtask

  task automatic test_branch_loaduse();
    idle(3);
    applyStimulus(5'd4, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    ex_branch_taken = 1'b1;
    applyStimulus(5'd10, 1'b1, 1'b0, 5'd4, 5'd0);
    checks++;
    if ({flush_id, bubble_ex, stall_if, stall_id, stall_ex} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL br_lu got %b want 11000", {flush_id, bubble_ex, stall_if, stall_id, stall_ex});
    end
    tick();
    ex_branch_taken = 1'b0;
    applyStimulus(5'd12, 1'b1, 1'b0, 5'd0, 5'd0);
    checks++;
    if (stall_if !== 1'b0 || flush_id !== 1'b0 || ex_mem_dest !== 5'd4) begin
      errors++;
      $display("[TB] FAIL br_after got stall_if=%0b flush=%0b dest=%0d want 0/0/4", stall_if, flush_id, ex_mem_dest);
    end
    tick();
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (ex_mem_dest !== 5'd0 || ex_mem_regwrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL br_bubble got dest=%0d rw=%0b want 0/0", ex_mem_dest, ex_mem_regwrite);
    end
    tick();
    checks++;
    if (ex_mem_dest !== 5'd12) begin
      errors++;
      $display("[TB] FAIL br_next got dest=%0d want 12", ex_mem_dest);
    end
  endtask

  task automatic test_mem_wait();
    idle(3);
    applyStimulus(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd11, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd12, 1'b1, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      ex_branch_taken = (i == 1);
      #1;
      checks++;
      if ({stall_if, stall_id, stall_ex, flush_id, bubble_ex} !== 5'b11100 || ex_mem_dest !== 5'd6 || mem_wb_dest !== 5'd0) begin
        errors++;
        $display("[TB] FAIL wait_%0d got ctl=%b ex_mem=%0d mem_wb=%0d want 11100/6/0", i,
                 {stall_if, stall_id, stall_ex, flush_id, bubble_ex}, ex_mem_dest, mem_wb_dest);
      end
      tick();
    end
    mem_ready = 1'b1;
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if ({stall_if, stall_id, stall_ex} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wait_release got %b want 000", {stall_if, stall_id, stall_ex});
    end
    tick();
    checks++;
    if (ex_mem_dest !== 5'd11 || mem_wb_dest !== 5'd6) begin
      errors++;
      $display("[TB] FAIL wait_advance got ex_mem=%0d mem_wb=%0d want 11/6", ex_mem_dest, mem_wb_dest);
    end
    applyStimulus(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    checks++;
    if (ex_mem_dest !== 5'd12) begin
      errors++;
      $display("[TB] FAIL wait_next got ex_mem=%0d want 12", ex_mem_dest);
    end
  endtask

`ifdef HZD_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    applyStimulus(5'd7, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    applyStimulus(5'd8, 1'b1, 1'b0, 5'd0, 5'd7);
    tick();
    tick();
    idle(2);
    applyStimulus(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    idle(1);
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    tick();
    ex_branch_taken = 1'b1;
    repeat (2) tick();
    ex_branch_taken = 1'b0;
    tick();
    checks++;
    if (perf_stall_cnt !== 32'd4 || perf_flush_cnt !== 32'd2) begin
      errors++;
      $display("[TB] FAIL perf_counts got stall=%0d flush=%0d want 4/2", perf_stall_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pipe_flow();
    test_load_use();
    test_branch_loaduse();
    test_mem_wait();
`ifdef HZD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
